// File: rtl/spi_if.sv
// SPI slave bus: serial pins toward the master plus the parallel frame/readback
// path toward the RAM stage.
interface spi_if;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave front end: assembles 10-bit command frames from MOSI for the RAM
// stage and serialises 8-bit read data back on MISO.
module spi_slave (
  input  logic     clk,
  input  logic     rst_n,
  spi_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Progress inside a data state: shifting the frame in, waiting for RAM read
  // data, shifting it out, or finished and ignoring MOSI until SS_n rises.
  typedef enum logic [1:0] {
    PH_SHIFT_IN,
    PH_WAIT_TX,
    PH_SHIFT_OUT,
    PH_DONE
  } phase_t;

  state_t     state, next_state;
  phase_t     phase, next_phase;

  logic [3:0] bit_cnt;
  logic [8:0] shift_reg;
  logic [7:0] tx_shift;
  logic       rd_addr_flag;
  logic       in_data_state;
  logic       frame_last;

  assign in_data_state = (state == WRITE) || (state == READ_ADD) || (state == READ_DATA);
  assign frame_last    = in_data_state && (phase == PH_SHIFT_IN) && (bit_cnt == 4'd8);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= PH_SHIFT_IN;
    end else begin
      state <= next_state;
      phase <= next_phase;
    end
  end

  // NOTE: defaults come first so every path assigns every output and no latch
  // is inferred.
  always_comb begin
    next_state = state;
    next_phase = phase;
    if (bus.SS_n) begin
      next_state = IDLE;
      next_phase = PH_SHIFT_IN;
    end else begin
      unique case (state)
        IDLE: begin
          next_state = CHK_CMD;
          next_phase = PH_SHIFT_IN;
        end
        CHK_CMD: begin
          next_phase = PH_SHIFT_IN;
          if (!bus.MOSI)         next_state = WRITE;
          else if (rd_addr_flag) next_state = READ_DATA;
          else                   next_state = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          unique case (phase)
            PH_SHIFT_IN: begin
              if (bit_cnt == 4'd8)
                next_phase = (state == READ_DATA) ? PH_WAIT_TX : PH_DONE;
            end
            PH_WAIT_TX: begin
              if (bus.tx_valid) next_phase = PH_SHIFT_OUT;
            end
            PH_SHIFT_OUT: begin
              if (bit_cnt == 4'd8) next_phase = PH_DONE;
            end
            PH_DONE: next_phase = PH_DONE;
            default: next_phase = PH_SHIFT_IN;
          endcase
        end
        default: begin
          next_state = IDLE;
          next_phase = PH_SHIFT_IN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= 4'd0;
      shift_reg    <= 9'd0;
      tx_shift     <= 8'd0;
      rd_addr_flag <= 1'b0;
      bus.rx_data  <= 10'h000;
      bus.rx_valid <= 1'b0;
      bus.MISO     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.MISO     <= 1'b0;
      if (bus.SS_n) begin
        // Abort: partial frame and pending shift-out are dropped, flag kept.
        bit_cnt <= 4'd0;
      end else begin
        unique case (state)
          IDLE: bit_cnt <= 4'd0;
          CHK_CMD: begin
            bit_cnt   <= 4'd0;
            shift_reg <= {8'd0, bus.MOSI};
          end
          WRITE, READ_ADD, READ_DATA: begin
            unique case (phase)
              PH_SHIFT_IN: begin
                if (frame_last) begin
                  bus.rx_data  <= {shift_reg, bus.MOSI};
                  bus.rx_valid <= 1'b1;
                  bit_cnt      <= 4'd0;
                  if (state == READ_ADD) rd_addr_flag <= 1'b1;
                end else begin
                  shift_reg <= {shift_reg[7:0], bus.MOSI};
                  bit_cnt   <= bit_cnt + 4'd1;
                end
              end
              PH_WAIT_TX: begin
                if (bus.tx_valid) tx_shift <= bus.tx_data;
              end
              PH_SHIFT_OUT: begin
                if (bit_cnt == 4'd8) begin
                  rd_addr_flag <= 1'b0;
                  bit_cnt      <= 4'd0;
                end else begin
                  bus.MISO <= tx_shift[7];
                  tx_shift <= {tx_shift[6:0], 1'b0};
                  bit_cnt  <= bit_cnt + 4'd1;
                end
              end
              default: bit_cnt <= bit_cnt;
            endcase
          end
          default: bit_cnt <= 4'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write/read frames, routing by the read-address
// flag, SS_n aborts and reset during readback.
module tb_spi_slave;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;
  int   valid_cnt;
  int   miso_cnt;

  spi_if bus ();

  spi_slave dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) valid_cnt++;
    if (bus.MISO === 1'b1) miso_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [9:0] f);
    bus.SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 0; i--) begin
      bus.MOSI = f[i];
      tick();
    end
  endtask

  task automatic end_frame();
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.rx_data !== 10'h000) $display("FAIL reset_rx_data: got %h expected 000", bus.rx_data); else passed++;
    checks++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); else passed++;
    checks++; if (bus.MISO !== 1'b0) $display("FAIL reset_miso: got %b expected 0", bus.MISO); else passed++;
    checks++; if (dut.rd_addr_flag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", dut.rd_addr_flag); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_addr();
    int v0, m0;
    v0 = valid_cnt;
    m0 = miso_cnt;
    send_frame(10'h005);
    checks++; if (bus.rx_data !== 10'h005) $display("FAIL wr_addr_data: got %h expected 005", bus.rx_data); else passed++;
    checks++; if (bus.rx_valid !== 1'b1) $display("FAIL wr_addr_valid_hi: got %b expected 1", bus.rx_valid); else passed++;
    tick();
    checks++; if (bus.rx_valid !== 1'b0) $display("FAIL wr_addr_valid_lo: got %b expected 0", bus.rx_valid); else passed++;
    bus.MOSI = 1'b1;
    repeat (4) tick();
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL wr_addr_pulses: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (bus.rx_data !== 10'h005) $display("FAIL wr_addr_hold: got %h expected 005", bus.rx_data); else passed++;
    end_frame();
    checks++; if (miso_cnt !== m0) $display("FAIL wr_addr_miso: got %0d high cycles expected 0", miso_cnt - m0); else passed++;
  endtask

  task automatic test_write_data();
    int v0, m0;
    v0 = valid_cnt;
    m0 = miso_cnt;
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    send_frame(10'h1AA);
    checks++; if (bus.rx_data !== 10'h1AA) $display("FAIL wr_data_data: got %h expected 1aa", bus.rx_data); else passed++;
    repeat (4) tick();
    end_frame();
    bus.tx_valid = 1'b0;
    checks++; if (valid_cnt - v0 !== 1) $display("FAIL wr_data_pulses: got %0d expected 1", valid_cnt - v0); else passed++;
    checks++; if (dut.rd_addr_flag !== 1'b0) $display("FAIL wr_data_flag: got %b expected 0", dut.rd_addr_flag); else passed++;
    checks++; if (miso_cnt !== m0) $display("FAIL wr_data_miso: got %0d high cycles expected 0", miso_cnt - m0); else passed++;
  endtask

  task automatic test_read();
    logic [7:0] exp;
    exp = 8'hA5;
    send_frame(10'h205);
    checks++; if (bus.rx_data !== 10'h205) $display("FAIL rd_addr_data: got %h expected 205", bus.rx_data); else passed++;
    checks++; if (dut.rd_addr_flag !== 1'b1) $display("FAIL rd_addr_flag: got %b expected 1", dut.rd_addr_flag); else passed++;
    end_frame();
    send_frame(10'h3C3);
    checks++; if (bus.rx_data !== 10'h3C3) $display("FAIL rd_data_frame: got %h expected 3c3", bus.rx_data); else passed++;
    checks++; if (bus.rx_valid !== 1'b1) $display("FAIL rd_data_valid: got %b expected 1", bus.rx_valid); else passed++;
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    checks++; if (bus.MISO !== 1'b0) $display("FAIL rd_latch_miso: got %b expected 0", bus.MISO); else passed++;
    for (int i = 7; i >= 0; i--) begin
      tick();
      checks++; if (bus.MISO !== exp[i]) $display("FAIL rd_miso_bit%0d: got %b expected %b", i, bus.MISO, exp[i]); else passed++;
    end
    tick();
    checks++; if (bus.MISO !== 1'b0) $display("FAIL rd_miso_after: got %b expected 0", bus.MISO); else passed++;
    checks++; if (dut.rd_addr_flag !== 1'b0) $display("FAIL rd_flag_clear: got %b expected 0", dut.rd_addr_flag); else passed++;
    end_frame();
  endtask

  task automatic test_consecutive_reads();
    logic [7:0] exp;
    int m0;
    exp = 8'h81;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m0 = miso_cnt;
    send_frame(10'h3FF);
    checks++; if (dut.rd_addr_flag !== 1'b1) $display("FAIL cons_first_flag: got %b expected 1", dut.rd_addr_flag); else passed++;
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    repeat (4) tick();
    bus.tx_valid = 1'b0;
    checks++; if (miso_cnt !== m0) $display("FAIL cons_first_miso: got %0d high cycles expected 0", miso_cnt - m0); else passed++;
    end_frame();
    send_frame(10'h300);
    checks++; if (bus.rx_data !== 10'h300) $display("FAIL cons_second_data: got %h expected 300", bus.rx_data); else passed++;
    bus.tx_data  = 8'h81;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      tick();
      checks++; if (bus.MISO !== exp[i]) $display("FAIL cons_miso_bit%0d: got %b expected %b", i, bus.MISO, exp[i]); else passed++;
    end
    tick();
    checks++; if (dut.rd_addr_flag !== 1'b0) $display("FAIL cons_flag_clear: got %b expected 0", dut.rd_addr_flag); else passed++;
    end_frame();
  endtask

  task automatic test_abort_write();
    logic [9:0] f;
    int v0;
    f  = 10'h0F0;
    v0 = valid_cnt;
    bus.SS_n = 1'b0;
    tick();
    for (int i = 9; i >= 5; i--) begin
      bus.MOSI = f[i];
      tick();
    end
    bus.SS_n = 1'b1;
    tick();
    checks++; if (bus.rx_valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", bus.rx_valid); else passed++;
    checks++; if (bus.rx_data !== 10'h300) $display("FAIL abort_hold: got %h expected 300", bus.rx_data); else passed++;
    tick();
    checks++; if (valid_cnt !== v0) $display("FAIL abort_pulses: got %0d expected 0", valid_cnt - v0); else passed++;
    send_frame(10'h0F0);
    checks++; if (bus.rx_data !== 10'h0F0) $display("FAIL abort_next_frame: got %h expected 0f0", bus.rx_data); else passed++;
    end_frame();
  endtask

  task automatic test_abort_read_shift();
    int m0;
    send_frame(10'h3AA);
    checks++; if (dut.rd_addr_flag !== 1'b1) $display("FAIL shabort_flag_set: got %b expected 1", dut.rd_addr_flag); else passed++;
    end_frame();
    m0 = miso_cnt;
    send_frame(10'h3BB);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (3) tick();
    checks++; if (bus.MISO !== 1'b1) $display("FAIL shabort_miso_active: got %b expected 1", bus.MISO); else passed++;
    bus.SS_n = 1'b1;
    tick();
    checks++; if (bus.MISO !== 1'b0) $display("FAIL shabort_miso_cut: got %b expected 0", bus.MISO); else passed++;
    checks++; if (dut.rd_addr_flag !== 1'b1) $display("FAIL shabort_flag_kept: got %b expected 1", dut.rd_addr_flag); else passed++;
    tick();
    checks++; if (miso_cnt - m0 !== 3) $display("FAIL shabort_miso_count: got %0d expected 3", miso_cnt - m0); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    int m0;
    send_frame(10'h3FF);
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    tick();
    bus.tx_valid = 1'b0;
    repeat (2) tick();
    checks++; if (bus.MISO !== 1'b1) $display("FAIL rstmid_miso_active: got %b expected 1", bus.MISO); else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.MISO !== 1'b0) $display("FAIL rstmid_miso: got %b expected 0", bus.MISO); else passed++;
    checks++; if (dut.rd_addr_flag !== 1'b0) $display("FAIL rstmid_flag: got %b expected 0", dut.rd_addr_flag); else passed++;
    checks++; if (bus.rx_data !== 10'h000) $display("FAIL rstmid_rx_data: got %h expected 000", bus.rx_data); else passed++;
    bus.SS_n = 1'b1;
    bus.MOSI = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    m0 = miso_cnt;
    send_frame(10'h301);
    checks++; if (dut.rd_addr_flag !== 1'b1) $display("FAIL rstmid_routes_read_add: got %b expected 1", dut.rd_addr_flag); else passed++;
    bus.tx_valid = 1'b1;
    repeat (3) tick();
    bus.tx_valid = 1'b0;
    checks++; if (miso_cnt !== m0) $display("FAIL rstmid_no_miso: got %0d high cycles expected 0", miso_cnt - m0); else passed++;
    end_frame();
  endtask

  initial begin
    checks       = 0;
    passed       = 0;
    valid_cnt    = 0;
    miso_cnt     = 0;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    test_reset();
    test_write_addr();
    test_write_data();
    test_read();
    test_consecutive_reads();
    test_abort_write();
    test_abort_read_shift();
    test_reset_mid_shift();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have no parameters; the frame is fixed at 10 bits in and 8 bits out.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 SS_n  input  1  slave select, active low; high frames a transaction boundary.
REQ-005 MOSI  input  1  serial data in, MSB first, sampled on clk rising edge.
REQ-006 MISO  output  1  serial data out, MSB first, registered.
REQ-007 rx_data  output  10  assembled frame to the RAM stage: [9:8] command, [7:0] address/data.
REQ-008 rx_valid  output  1  one-cycle strobe qualifying rx_data.
REQ-009 tx_data  input  8  read data returned by the RAM stage.
REQ-010 tx_valid  input  1  qualifies tx_data; sampled only in READ_DATA after the frame is issued.

Function
REQ-011 FSM states SHALL be IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE -> CHK_CMD on the edge sampling SS_n=0; otherwise stay in IDLE.
REQ-013 CHK_CMD: sample MOSI as rx_data[9]; MOSI=0 -> WRITE; MOSI=1 with rd_addr_flag=0 -> READ_ADD; MOSI=1 with rd_addr_flag=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA SHALL shift in 9 further MOSI bits (rx_data[8] down to [0]) on 9 consecutive edges via a 4-bit bit counter.
REQ-015 rx_valid SHALL be high for exactly one cycle, starting the cycle after the edge sampling bit 0, with the full 10-bit frame stable on rx_data.
REQ-016 rx_data SHALL hold its last complete frame until the next complete frame; partial shifts use an internal register.
REQ-017 rd_addr_flag SHALL set when a READ_ADD frame completes and clear when a READ_DATA transfer finishes its 8th MISO bit.
REQ-018 The frame's [9:8] bits SHALL pass through unmodified; no check of bit 8 is performed here.
REQ-019 READ_DATA: after rx_valid, wait for tx_valid=1; on that edge latch tx_data; on the next 8 edges drive MISO = tx_data[7] down to [0], one bit per cycle.
REQ-020 MISO SHALL be 0 at all times other than the 8 data-bit cycles.
REQ-021 After a completed frame (and, for READ_DATA, the 8 MISO bits), further MOSI bits SHALL be ignored until SS_n returns high.
REQ-022 SS_n sampled high in any state SHALL force IDLE on that edge: partial frame discarded, no rx_valid, MISO=0, bit counters cleared, rd_addr_flag unchanged.
REQ-023 SS_n rising during MISO shifting SHALL abort the shift and leave rd_addr_flag set.
REQ-024 tx_valid outside the READ_DATA wait phase SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, rx_data=10'h000, rx_valid=0, MISO=0, rd_addr_flag=0, counters=0.
REQ-026 Reset asserted mid-transaction SHALL discard all progress; after release the block waits for the next SS_n falling sample.

Verification
REQ-027 Write address: SS_n=0, MOSI 00_0000_0101 -> rx_data=10'h005, rx_valid high exactly 1 cycle, MISO stays 0.
REQ-028 Write data: frame 01_1010_1010 -> rx_data=10'h1AA, one rx_valid pulse, rd_addr_flag=0.
REQ-029 Read: frame 10_0000_0101 then SS_n high, frame 11_xxxx_xxxx, tx_valid=1 with tx_data=8'hA5 -> rx_data=10'h3xx pulse, MISO=1,0,1,0,0,1,0,1 on 8 consecutive cycles, then flag=0.
REQ-030 Two consecutive frames beginning with 1 and no read-address frame before -> first routes to READ_ADD, second to READ_DATA.
REQ-031 SS_n high after 5 bits of a write -> no rx_valid, rx_data unchanged, state IDLE next cycle.
REQ-032 rst_n low during MISO shift of 8'hFF -> MISO=0 immediately, flag=0, next 11_... frame routes to READ_ADD.
